// File: rtl/player_action_fsm_if.sv
// Controller-to-fighter bus: tick/controller vector in, fighter state out.
// PROTOCOL_CHECK_EN adds the sticky proto_err flag.
interface player_action_fsm_if;
    logic       frame_tick;
    logic [6:0] controller_inputs;
    logic [9:0] pos_x;
    logic [7:0] jump_y;
    logic [2:0] action;
    logic       attack_active;
    logic       shield_active;
    logic       facing_right;
`ifdef PROTOCOL_CHECK_EN
    logic       proto_err;
`endif

    modport master (
`ifdef PROTOCOL_CHECK_EN
        input  proto_err,
`endif
        output frame_tick, controller_inputs,
        input  pos_x, jump_y, action, attack_active, shield_active, facing_right
    );

    modport slave (
`ifdef PROTOCOL_CHECK_EN
        output proto_err,
`endif
        input  frame_tick, controller_inputs,
        output pos_x, jump_y, action, attack_active, shield_active, facing_right
    );
endinterface

// File: rtl/player_action_fsm.sv
// Per-player fighter action FSM: decodes controller vector into action/position/jump, once per frame.
// Optional macro PROTOCOL_CHECK_EN adds a sticky non-one-hot movement flag (proto_err).
module player_action_fsm #(
    parameter int unsigned X_MIN           = 0,
    parameter int unsigned X_MAX           = 575,
    parameter int unsigned X_INIT          = 100,
    parameter int unsigned WALK_STEP       = 4,
    parameter int unsigned JUMP_HEIGHT     = 64,
    parameter int unsigned JUMP_STEP       = 4,
    parameter int unsigned ATTACK_FRAMES   = 12,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    player_action_fsm_if.slave   bus
);

    localparam int unsigned PW  = 10;
    localparam int unsigned PXW = PW + 1;
    localparam int unsigned JW  = 8;
    localparam int unsigned ACW = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;
    localparam int unsigned CDW = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WALK      = 3'd1,
        ST_CROUCH    = 3'd2,
        ST_JUMP_UP   = 3'd3,
        ST_JUMP_DOWN = 3'd4,
        ST_ATTACK    = 3'd5,
        ST_SHIELD    = 3'd6
    } state_t;

    state_t         state, state_n;
    logic [PW-1:0]  pos_x_q, pos_n;
    logic [JW-1:0]  jump_q, jump_n;
    logic           facing_q, facing_n;
    logic           attack_active_q, shield_active_q;
    logic [ACW-1:0] attack_cnt, attack_cnt_n;
    logic [CDW-1:0] cooldown, cooldown_n;
    logic           attack_prev;

    logic [4:0]     mv;
    logic           mv_onehot, mv_down, mv_right, mv_up, mv_left;
    logic           attack_edge;
    logic [PXW-1:0] pos_ext, pos_right_sum;
    logic [PW-1:0]  pos_right, pos_left;
    logic [JW:0]    jump_up_sum;

    // Movement decode: anything other than exactly one bit set counts as center
    assign mv          = bus.controller_inputs[4:0];
    assign mv_onehot   = (mv != 5'd0) && ((mv & (mv - 5'd1)) == 5'd0);
    assign mv_down     = mv_onehot & mv[1];
    assign mv_right    = mv_onehot & mv[2];
    assign mv_up       = mv_onehot & mv[3];
    assign mv_left     = mv_onehot & mv[4];
    assign attack_edge = bus.controller_inputs[5] & ~attack_prev;

    // 11-bit position math so stepping left of X_MIN cannot wrap before clamping
    assign pos_ext       = {1'b0, pos_x_q};
    assign pos_right_sum = pos_ext + PXW'(WALK_STEP);
    assign pos_right     = (pos_right_sum > PXW'(X_MAX)) ? PW'(X_MAX) : pos_right_sum[PW-1:0];
    assign pos_left      = (pos_ext < PXW'(X_MIN + WALK_STEP)) ? PW'(X_MIN)
                                                               : PW'(pos_ext - PXW'(WALK_STEP));
    assign jump_up_sum   = {1'b0, jump_q} + (JW+1)'(JUMP_STEP);

    always_comb begin
        state_n      = state;
        pos_n        = pos_x_q;
        jump_n       = jump_q;
        facing_n     = facing_q;
        attack_cnt_n = attack_cnt;
        cooldown_n   = (cooldown != '0) ? cooldown - CDW'(1) : cooldown;

        case (state)
            ST_IDLE, ST_WALK, ST_CROUCH, ST_SHIELD: begin
                if (attack_edge && (cooldown == '0)) begin
                    state_n      = ST_ATTACK;
                    attack_cnt_n = ACW'(ATTACK_FRAMES - 1);
                end else if (bus.controller_inputs[6]) begin
                    state_n = ST_SHIELD;
                    if (mv_right || mv_left) facing_n = mv_right;
                end else if (mv_up) begin
                    state_n = ST_JUMP_UP;
                    jump_n  = JW'(JUMP_STEP);
                end else if (mv_right || mv_left) begin
                    state_n  = ST_WALK;
                    facing_n = mv_right;
                    // Leaving shield, the first horizontal press only turns the fighter
                    if (state != ST_SHIELD) pos_n = mv_right ? pos_right : pos_left;
                end else if (mv_down) begin
                    state_n = ST_CROUCH;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_JUMP_UP, ST_JUMP_DOWN: begin
                if (state == ST_JUMP_UP) begin
                    if (jump_up_sum >= (JW+1)'(JUMP_HEIGHT)) begin
                        jump_n  = JW'(JUMP_HEIGHT);
                        state_n = ST_JUMP_DOWN;
                    end else begin
                        jump_n = jump_up_sum[JW-1:0];
                    end
                end else if (jump_q <= JW'(JUMP_STEP)) begin
                    jump_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    jump_n = jump_q - JW'(JUMP_STEP);
                end
                if (mv_right) begin
                    pos_n    = pos_right;
                    facing_n = 1'b1;
                end else if (mv_left) begin
                    pos_n    = pos_left;
                    facing_n = 1'b0;
                end
            end
            ST_ATTACK: begin
                if (attack_cnt == '0) begin
                    state_n    = ST_IDLE;
                    cooldown_n = CDW'(COOLDOWN_FRAMES);
                end else begin
                    attack_cnt_n = attack_cnt - ACW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            pos_x_q         <= PW'(X_INIT);
            jump_q          <= '0;
            facing_q        <= 1'b1;
            attack_active_q <= 1'b0;
            shield_active_q <= 1'b0;
            attack_cnt      <= '0;
            cooldown        <= '0;
            attack_prev     <= 1'b1;
        end else if (bus.frame_tick) begin
            state           <= state_n;
            pos_x_q         <= pos_n;
            jump_q          <= jump_n;
            facing_q        <= facing_n;
            attack_active_q <= (state_n == ST_ATTACK);
            shield_active_q <= (state_n == ST_SHIELD);
            attack_cnt      <= attack_cnt_n;
            cooldown        <= cooldown_n;
            attack_prev     <= bus.controller_inputs[5];
        end
    end

`ifdef PROTOCOL_CHECK_EN
    logic proto_err_q;

    always_ff @(posedge clk) begin
        if (reset)               proto_err_q <= 1'b0;
        else if (bus.frame_tick) proto_err_q <= proto_err_q | ~mv_onehot;
    end

    assign bus.proto_err = proto_err_q;
`endif

    assign bus.pos_x         = pos_x_q;
    assign bus.jump_y        = jump_q;
    assign bus.action        = state;
    assign bus.attack_active = attack_active_q;
    assign bus.shield_active = shield_active_q;
    assign bus.facing_right  = facing_q;

endmodule

// File: tb/tb_player_action_fsm.sv
// Directed self-checking bench for player_action_fsm; build with +define+PROTOCOL_CHECK_EN to also check proto_err.
module tb_player_action_fsm;

    localparam logic [6:0] C_CENTER = 7'b0000001;
    localparam logic [6:0] C_DOWN   = 7'b0000010;
    localparam logic [6:0] C_RIGHT  = 7'b0000100;
    localparam logic [6:0] C_UP     = 7'b0001000;
    localparam logic [6:0] C_LEFT   = 7'b0010000;
    localparam logic [6:0] C_ATK    = 7'b0100000;
    localparam logic [6:0] C_SH     = 7'b1000000;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    player_action_fsm_if bus();

    player_action_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame tick with the given controller vector; returns on the following falling edge
    task automatic tick(input logic [6:0] ci);
        @(negedge clk);
        bus.controller_inputs = ci;
        bus.frame_tick        = 1'b1;
        @(negedge clk);
        bus.frame_tick        = 1'b0;
    endtask

    task automatic do_reset(input logic [6:0] ci);
        @(negedge clk);
        bus.controller_inputs = ci;
        bus.frame_tick        = 1'b1;
        reset                 = 1'b1;
        repeat (2) @(negedge clk);
        reset          = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        reset                 = 1'b1;
        bus.frame_tick        = 1'b0;
        bus.controller_inputs = C_CENTER;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_pos_x",  16'(bus.pos_x), 16'(100));
        check("rst_jump_y", 16'(bus.jump_y), 16'(0));
        check("rst_action", 16'(bus.action), 16'(0));
        check("rst_attack", 16'(bus.attack_active), 16'(0));
        check("rst_shield", 16'(bus.shield_active), 16'(0));
        check("rst_facing", 16'(bus.facing_right), 16'(1));
`ifdef PROTOCOL_CHECK_EN
        check("rst_proto_err", 16'(bus.proto_err), 16'(0));
`endif

        // No tick: registers hold even with movement requested
        bus.controller_inputs = C_RIGHT;
        repeat (3) @(negedge clk);
        check("hold_pos_x",  16'(bus.pos_x), 16'(100));
        check("hold_action", 16'(bus.action), 16'(0));

        for (int k = 1; k <= 10; k++) begin
            tick(C_RIGHT);
            check("walk_right_pos", 16'(bus.pos_x), 16'(100 + 4 * k));
        end
        check("walk_action", 16'(bus.action), 16'(1));
        check("walk_facing", 16'(bus.facing_right), 16'(1));
        tick(C_CENTER);
        check("center_action", 16'(bus.action), 16'(0));
        check("center_pos",    16'(bus.pos_x), 16'(140));
        tick(C_DOWN);
        check("crouch_action", 16'(bus.action), 16'(2));

        // Left saturation at X_MIN
        do_reset(C_CENTER);
        for (int k = 1; k <= 30; k++) begin
            tick(C_LEFT);
            check("walk_left_pos", 16'(bus.pos_x), 16'((4 * k <= 100) ? (100 - 4 * k) : 0));
        end
        check("left_facing", 16'(bus.facing_right), 16'(0));

        // Right saturation at X_MAX
        do_reset(C_CENTER);
        for (int k = 1; k <= 120; k++) begin
            tick(C_RIGHT);
            if (k >= 118)
                check("xmax_pos", 16'(bus.pos_x), 16'((k == 118) ? 572 : 575));
        end

        // Jump arc with right drift
        do_reset(C_CENTER);
        tick(C_UP);
        check("jump_t1_y",      16'(bus.jump_y), 16'(4));
        check("jump_t1_action", 16'(bus.action), 16'(3));
        for (int k = 2; k <= 32; k++) begin
            tick(C_RIGHT);
            check("jump_y", 16'(bus.jump_y), 16'((k <= 16) ? 4 * k : 64 - 4 * (k - 16)));
            check("jump_action", 16'(bus.action), 16'((k < 16) ? 3 : ((k < 32) ? 4 : 0)));
            check("jump_drift_pos", 16'(bus.pos_x), 16'(100 + 4 * (k - 1)));
        end

        // Attack held through reset does not fire; then a held attack lasts 12 ticks
        do_reset(C_ATK);
        tick(C_ATK);
        check("atk_thru_rst_action", 16'(bus.action), 16'(0));
        check("atk_thru_rst_active", 16'(bus.attack_active), 16'(0));
        tick(C_CENTER);
        for (int k = 1; k <= 30; k++) begin
            tick(C_ATK);
            check("atk_hold_active", 16'(bus.attack_active), 16'((k <= 12) ? 1 : 0));
            check("atk_hold_action", 16'(bus.action), 16'((k <= 12) ? 5 : 0));
        end

        // Cooldown: attack ends at tick 13, cooldown 8 counts down ticks 14..21
        do_reset(C_CENTER);
        tick(C_CENTER);
        tick(C_ATK);
        check("cd_atk_start", 16'(bus.action), 16'(5));
        for (int k = 2; k <= 13; k++) tick(C_CENTER);
        check("cd_atk_end", 16'(bus.action), 16'(0));
        tick(C_CENTER);
        tick(C_CENTER);
        tick(C_ATK);
        check("cd_refuse_early", 16'(bus.action), 16'(0));
        for (int k = 17; k <= 20; k++) tick(C_CENTER);
        tick(C_ATK);
        check("cd_refuse_last", 16'(bus.attack_active), 16'(0));
        tick(C_CENTER);
        tick(C_ATK);
        check("cd_accept_action", 16'(bus.action), 16'(5));
        check("cd_accept_active", 16'(bus.attack_active), 16'(1));

        // Same-tick priority conflicts
        do_reset(C_CENTER);
        tick(C_CENTER);
        tick(C_ATK | C_SH | C_RIGHT);
        check("conf_atk_action", 16'(bus.action), 16'(5));
        check("conf_atk_pos",    16'(bus.pos_x), 16'(100));
        check("conf_atk_shield", 16'(bus.shield_active), 16'(0));
        do_reset(C_CENTER);
        tick(C_SH | C_UP);
        check("conf_sh_action", 16'(bus.action), 16'(6));
        check("conf_sh_active", 16'(bus.shield_active), 16'(1));
        check("conf_sh_jump",   16'(bus.jump_y), 16'(0));
        tick(C_SH | C_LEFT);
        check("sh_turn_facing", 16'(bus.facing_right), 16'(0));
        check("sh_turn_pos",    16'(bus.pos_x), 16'(100));
        do_reset(C_CENTER);
        tick(7'b0000110);
        check("multi_bit_action", 16'(bus.action), 16'(0));
        check("multi_bit_pos",    16'(bus.pos_x), 16'(100));
`ifdef PROTOCOL_CHECK_EN
        check("proto_err_set", 16'(bus.proto_err), 16'(1));
        tick(C_CENTER);
        check("proto_err_sticky", 16'(bus.proto_err), 16'(1));
`endif

        // Reset mid-jump, with attack held through it
        do_reset(C_CENTER);
        tick(C_UP);
        for (int k = 2; k <= 10; k++) tick(C_RIGHT);
        check("midjump_y",   16'(bus.jump_y), 16'(40));
        check("midjump_pos", 16'(bus.pos_x), 16'(136));
        @(negedge clk);
        bus.controller_inputs = C_ATK;
        reset                 = 1'b1;
        @(negedge clk);
        check("rst_jump_y_now", 16'(bus.jump_y), 16'(0));
        check("rst_jump_pos",   16'(bus.pos_x), 16'(100));
        check("rst_jump_act",   16'(bus.action), 16'(0));
        reset = 1'b0;
        tick(C_ATK);
        check("rst_atk_held_action", 16'(bus.action), 16'(0));
        check("rst_atk_held_active", 16'(bus.attack_active), 16'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_action_fsm.md
Name: player_action_fsm

Overview:
- Consumer side of the 7-bit controller vector produced by the controller interface block.
- Decodes the movement one-hot and the attack/shield bits into one fighter's action state, horizontal position and jump height, advancing once per video frame.
- Sits between the controller interface and the sprite renderer / hit-detection logic; one instance per player.

Parameters:
- X_MIN, 0, leftmost allowed pos_x.
- X_MAX, 575, rightmost allowed pos_x.
- X_INIT, 100, pos_x after reset.
- WALK_STEP, 4, pixels moved per frame while walking or drifting in air.
- JUMP_HEIGHT, 64, apex of jump_y.
- JUMP_STEP, 4, jump_y change per frame.
- ATTACK_FRAMES, 12, frames attack_active stays high per attack.
- COOLDOWN_FRAMES, 8, frames after an attack during which new attacks are refused.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame; all state advances only on cycles where it is high.
- controller_inputs  in  7  [0]=center, [1]=down, [2]=right, [3]=up, [4]=left, [5]=attack, [6]=shield; all active high.
- pos_x  out  10  fighter horizontal position.
- jump_y  out  8  height above ground, 0 = grounded.
- action  out  3  0=IDLE, 1=WALK, 2=CROUCH, 3=JUMP_UP, 4=JUMP_DOWN, 5=ATTACK, 6=SHIELD.
- attack_active  out  1  high while action==ATTACK.
- shield_active  out  1  high while action==SHIELD.
- facing_right  out  1  1 = facing right.

Behaviour:
- Reset:
  - Synchronous, active-high; reset wins over frame_tick.
  - Values after reset: pos_x=X_INIT, jump_y=0, action=IDLE, attack_active=0, shield_active=0, facing_right=1, attack and cooldown counters=0, attack_prev=1.
  - Because attack_prev resets to 1, an attack held through reset does not fire.
  - Reset mid-jump or mid-attack returns to ground/IDLE at once.
- Timing:
  - All outputs are registered.
  - On a clk edge with frame_tick=1, the new values are visible after that edge (one-cycle latency from the tick).
  - With frame_tick=0, every register holds.
- Movement decode: bits [4:0] are valid only if exactly one bit is set. Any other pattern (zero or multiple bits) is treated as center.
- attack_edge = controller_inputs[5] & ~attack_prev.
  - attack_prev updates on every tick in every state, so holding the button never retriggers.
- Cooldown counter: when nonzero, it decrements by 1 on every tick in every state.
- Grounded states (IDLE, WALK, CROUCH, SHIELD), checked each tick in priority order:
  1. attack_edge and cooldown==0 → ATTACK, attack counter=ATTACK_FRAMES-1.
  2. shield bit → SHIELD.
  3. up → JUMP_UP.
  4. right/left → WALK; pos_x ±WALK_STEP, saturating to [X_MIN, X_MAX]; facing_right set to 1 or 0 accordingly.
  5. down → CROUCH.
  6. otherwise → IDLE.
- SHIELD: the first horizontal press while shielding changes facing only; pos_x does not change.
- ATTACK:
  - No movement; input bits other than attack_prev tracking are ignored.
  - Each tick: if counter==0, go to IDLE and load cooldown=COOLDOWN_FRAMES; else decrement the counter.
- JUMP_UP:
  - jump_y += JUMP_STEP.
  - If the result is ≥ JUMP_HEIGHT, clamp jump_y to JUMP_HEIGHT and go to JUMP_DOWN.
- JUMP_DOWN:
  - If jump_y ≤ JUMP_STEP, set jump_y=0 and go to IDLE; else jump_y -= JUMP_STEP.
- In the air (both jump states):
  - Left/right drift pos_x by ±WALK_STEP with saturation and update facing.
  - Attack, shield and down are ignored; attack_prev still tracks the button.
- Width rule: pos_x arithmetic uses 11 bits, so X_MIN-WALK_STEP never wraps before the clamp.

Optional Feature:
- Macro: PROTOCOL_CHECK_EN.
- Defined:
  - Adds output port proto_err (1 bit), reset to 0.
  - proto_err is sticky: it sets on any tick where controller_inputs[4:0] is not exactly one-hot, and clears only on reset.
  - Decoding is unchanged (the pattern is still treated as center).
- Undefined: port and logic absent; decode behaviour identical.

Test Plan:
- Reset, then right held for 10 ticks → pos_x 100→140, action=WALK, facing_right=1; center for 1 tick → action=IDLE.
- Left held for 30 ticks from 100 → pos_x reaches 0 at tick 25 and stays 0, no wrap; facing_right=0.
- Up for 1 tick, then center → jump_y rises 4 per tick to 64 at tick 16 (JUMP_DOWN), reaches 0 and IDLE at tick 32; right held during the jump moves pos_x +4 per tick.
- Attack held for 30 ticks → attack_active=1 for exactly 12 ticks, then IDLE with no retrigger.
- Release attack, then re-press 3 ticks after the attack ends → refused; re-press after 8 cooldown ticks → ATTACK starts.
- Same-tick conflicts: attack edge with shield and right → ATTACK wins; shield and up together → SHIELD; controller_inputs[4:0]=5'b00110 → IDLE, and proto_err=1 when PROTOCOL_CHECK_EN is defined.
- Reset asserted at jump_y=40 → next cycle jump_y=0, pos_x=100, action=IDLE; attack held through reset → no attack.
